axi4_lite_slave_regs: RTL and testbench
=======================================

# axi4_lite_slave_regs

Synthesizable AXI4-Lite slave register bank that terminates the transactions issued by the AXI4-Lite master BFM. It serves as the default DUT-side endpoint in C2SIF-driven scenarios. It holds NUM_REGS 32-bit registers that are writable with byte strobes and readable back. All register values are exported as a flat vector, and a per-register write pulse is provided for downstream logic.

## Interface
- NUM_REGS, 16: number of 32-bit registers; legal 1..256.
- BASE_ADDR, 32'h0000_0000: byte address of register 0; must be aligned to NUM_REGS*4 rounded up to a power of two.
- RESET_VAL, 32'h0000_0000: reset value of every register.
- aclk  in  1  single clock; all logic is on the rising edge.
- areset  in  1  synchronous, active-high reset.
- s_awaddr  in  32  write address.
- s_awcache  in  4  accepted and ignored.
- s_awprot  in  3  accepted and ignored.
- s_awvalid / s_awready  in / out  1  AW handshake.
- s_wdata  in  32  write data.
- s_wstrb  in  4  byte enables; bit i selects wdata[8i+7:8i].
- s_wvalid / s_wready  in / out  1  W handshake.
- s_bresp  out  2  write response.
- s_bvalid / s_bready  out / in  1  B handshake.
- s_araddr  in  32  read address.
- s_arcache  in  4  accepted and ignored.
- s_arprot  in  3  accepted and ignored.
- s_arvalid / s_arready  in / out  1  AR handshake.
- s_rdata  out  32  read data.
- s_rresp  out  2  read response.
- s_rvalid / s_rready  out / in  1  R handshake.
- reg_q  out  NUM_REGS*32  register contents; reg k occupies [32k+31:32k].
- reg_wr_pulse  out  NUM_REGS  one-cycle pulse on the cycle after reg k is updated.

## Operation
- Address decode uses idx = (addr - BASE_ADDR) >> 2. Bits [1:0] are ignored.
  - The address is in range iff addr >= BASE_ADDR and idx < NUM_REGS.
  - Out of range: DECERR (2'b11); no register change; read data 32'h0.
  - In range: OKAY (2'b00). SLVERR is never generated.
- Write FSM states: W_IDLE, W_COMMIT, W_RESP.
  - AW and W are captured independently into holding registers, in any order, on any cycles.
  - Once a channel's handshake completes, its ready drops and stays low until that write's B handshake completes.
  - When both holding registers are full, the FSM enters W_COMMIT. On that edge it writes the masked bytes, drives bvalid, and moves to W_RESP.
  - bresp holds stable while bvalid=1.
  - On a B handshake, awready and wready return to 1 and the FSM returns to W_IDLE.
  - wstrb=4'h0 to an in-range address returns OKAY; the register is unchanged and reg_wr_pulse still fires.
- Read FSM states: R_IDLE, R_RESP.
  - On an AR handshake, arready drops.
  - On the next edge, rdata and rresp are loaded and rvalid=1.
  - rdata and rresp hold stable until the R handshake. The handshake returns arready to 1.
- The read and write paths are fully independent and may be active concurrently.

## Timing
- During reset and the first edge after it, every output is 0 except reg_q, which is RESET_VAL in every slot.
- awready, wready and arready rise on the first edge with areset=0.
- Write latency, with AW and W accepted together at edge E:
  - registers update and bvalid rises at E+1;
  - with bready=1, B completes at E+2 and the readies return at E+2;
  - best case is one write per 3 cycles.
- If AW is accepted at E and W at E+k, the commit happens at E+k+1.
- Read latency: AR accepted at E; rvalid rises at E+1; with rready=1, the transaction ends at E+2.
- A read loading on the same edge as a write commit to the same register returns the pre-write value.
- Reset asserted mid-transaction:
  - outstanding transactions are dropped;
  - all state and registers are reinitialised at that edge;
  - no B or R is ever issued for them.
- The held outputs (bvalid/bresp and rvalid/rdata/rresp) do not change while valid=1 and ready=0.

## Structure
- Shared package axi4_lite_pkg provides:
  - response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - the write-FSM and read-FSM state enums.
- Sub-module axi4_lite_reg_bank contains the register array, the strobe merge, reg_wr_pulse generation and the combinational read mux. The top level holds the handshakes and the decode.

## Test plan
- After reset, read 0x0C -> rdata=RESET_VAL, rresp=OKAY; reg_q equals RESET_VAL in all slots.
- Write 0x04 with data 32'hA5A5_1234, wstrb=4'hF; then write 0x04 with data 32'hFFFF_FFFF, wstrb=4'b0101 -> read 0x04 returns 32'hA5FF_12FF; reg_wr_pulse[1] fires twice.
- W presented 3 cycles before AW, then AW presented -> one commit only, occurring 1 cycle after the AW handshake; bresp=OKAY.
- Write, then read, at BASE_ADDR+NUM_REGS*4 -> bresp=DECERR, rresp=DECERR, rdata=0; reg_q unchanged.
- Hold bready=0 and rready=0 for 5 cycles -> bvalid, rvalid and the response/data stay constant; awready, wready and arready stay 0; no second transaction is accepted.
- Assert areset while bvalid=1 -> next cycle bvalid=0, registers equal RESET_VAL, and the readies are 0; then 1 on the following edge.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// ============================================================================
// Package  : axi4_lite_pkg
// Purpose  : Shared AXI4-Lite response codes, slave FSM state encodings and
//            the address-window decode helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package axi4_lite_pkg;

    // AXI4-Lite response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Write-channel FSM states
    localparam logic [1:0] W_IDLE   = 2'd0;
    localparam logic [1:0] W_COMMIT = 2'd1;
    localparam logic [1:0] W_RESP   = 2'd2;

    // Read-channel FSM states
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_RESP = 1'b1;

    // An address hits the bank when it is at or above the base and its word
    // offset from the base is below the register count. The byte lane bits
    // are discarded by the shift.
    function automatic logic addr_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int unsigned num);
        logic [31:0] off;
        off = addr - base;
        return (addr >= base) && ((off >> 2) < num);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_lite_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_reg_bank
// Purpose  : Array of 32-bit registers with byte-strobe write merge, a
//            one-cycle write pulse per register and a combinational read mux.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            i_wr_en             - commit strobe (already range-qualified)
//            i_wr_idx/data/strb  - target register, data, byte enables
//            i_rd_idx, o_rd_data - combinational read port
//            o_reg_q             - flat register contents, reg k at [32k+:32]
//            o_reg_wr_pulse      - pulse in the cycle after reg k is written
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_reg_bank
    import axi4_lite_pkg::*;
#(
    parameter int          NUM_REGS  = 16,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000,
    parameter int          IDX_W     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [IDX_W-1:0]         i_wr_idx,
    input  logic [31:0]              i_wr_data,
    input  logic [3:0]               i_wr_strb,
    input  logic [IDX_W-1:0]         i_rd_idx,
    output logic [31:0]              o_rd_data,
    output logic [NUM_REGS*32-1:0]   o_reg_q,
    output logic [NUM_REGS-1:0]      o_reg_wr_pulse
);

    logic [31:0]          r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]  r_pulse;
    logic [NUM_REGS-1:0]  w_sel;
    logic [31:0]          w_mask;

    assign w_mask = {{8{i_wr_strb[3]}}, {8{i_wr_strb[2]}},
                     {8{i_wr_strb[1]}}, {8{i_wr_strb[0]}}};

    generate
        for (genvar k = 0; k < NUM_REGS; k++) begin : g_sel
            assign w_sel[k] = i_wr_en && (i_wr_idx == IDX_W'(k));
            assign o_reg_q[32*k +: 32] = r_regs[k];
        end
    endgenerate

    // A zero strobe still selects the register, so the pulse fires even
    // though no byte changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= RESET_VAL;
            end
            r_pulse <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (w_sel[k]) begin
                    r_regs[k] <= (r_regs[k] & ~w_mask) | (i_wr_data & w_mask);
                end
            end
            r_pulse <= w_sel;
        end
    end

    assign o_reg_wr_pulse = r_pulse;

    always_comb begin
        o_rd_data = 32'h0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (i_rd_idx == IDX_W'(k)) begin
                o_rd_data = r_regs[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi4_lite_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_slave_regs
// Purpose  : AXI4-Lite slave terminating reads and writes into a bank of
//            NUM_REGS byte-writable 32-bit registers.
// Ports    : aclk, areset        - clock, synchronous active-high reset
//            s_aw*/s_w*/s_b*     - write address, data and response channels
//            s_ar*/s_r*          - read address and data channels
//            reg_q               - flat register contents
//            reg_wr_pulse        - per-register write pulse
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_slave_regs
    import axi4_lite_pkg::*;
#(
    parameter int          NUM_REGS  = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [31:0]             s_awaddr,
    input  logic [3:0]              s_awcache,
    input  logic [2:0]              s_awprot,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [31:0]             s_wdata,
    input  logic [3:0]              s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [31:0]             s_araddr,
    input  logic [3:0]              s_arcache,
    input  logic [2:0]              s_arprot,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [31:0]             s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    output logic [NUM_REGS*32-1:0]  reg_q,
    output logic [NUM_REGS-1:0]     reg_wr_pulse
);

    localparam int c_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    // ------------------------------------------------------------------
    // Write path state
    // ------------------------------------------------------------------
    logic        r_awready, r_aw_full;
    logic [31:0] r_awaddr;
    logic        r_wready, r_w_full;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_wstate;
    logic        r_bvalid;
    logic [1:0]  r_bresp;

    // ------------------------------------------------------------------
    // Read path state
    // ------------------------------------------------------------------
    logic        r_arready, r_ar_pend;
    logic [31:0] r_araddr;
    logic [0:0]  r_rstate;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;

    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic [31:0] w_aw_off, w_ar_off;
    logic [c_IDX_W-1:0] w_wr_idx, w_rd_idx;
    logic w_wr_hit, w_rd_hit, w_wr_en;
    logic [31:0] w_bank_rd;
    logic w_unused;

    assign w_aw_hs = s_awvalid && r_awready;
    assign w_w_hs  = s_wvalid  && r_wready;
    assign w_b_hs  = r_bvalid  && s_bready;
    assign w_ar_hs = s_arvalid && r_arready;
    assign w_r_hs  = r_rvalid  && s_rready;

    // Decode always works from the held addresses, never the live buses.
    assign w_aw_off = r_awaddr - BASE_ADDR;
    assign w_ar_off = r_araddr - BASE_ADDR;
    assign w_wr_idx = w_aw_off[c_IDX_W+1:2];
    assign w_rd_idx = w_ar_off[c_IDX_W+1:2];
    assign w_wr_hit = addr_hit(r_awaddr, BASE_ADDR, NUM_REGS);
    assign w_rd_hit = addr_hit(r_araddr, BASE_ADDR, NUM_REGS);
    assign w_wr_en  = (r_wstate == W_COMMIT) && w_wr_hit;

    // Cache/prot qualifiers carry no meaning for a plain register bank.
    assign w_unused = ^{s_awcache, s_awprot, s_arcache, s_arprot,
                        w_aw_off, w_ar_off};

    // AW holding register. Ready is registered so it stays low out of
    // reset and rises on the first edge with reset released.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_awready <= 1'b0;
            r_aw_full <= 1'b0;
            r_awaddr  <= 32'h0;
        end else if (w_b_hs) begin
            r_awready <= 1'b1;
            r_aw_full <= 1'b0;
        end else if (w_aw_hs) begin
            r_awready <= 1'b0;
            r_aw_full <= 1'b1;
            r_awaddr  <= s_awaddr;
        end else if (!r_aw_full && (r_wstate == W_IDLE)) begin
            r_awready <= 1'b1;
        end
    end

    // W holding register, mirrors the AW holder.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wready <= 1'b0;
            r_w_full <= 1'b0;
            r_wdata  <= 32'h0;
            r_wstrb  <= 4'h0;
        end else if (w_b_hs) begin
            r_wready <= 1'b1;
            r_w_full <= 1'b0;
        end else if (w_w_hs) begin
            r_wready <= 1'b0;
            r_w_full <= 1'b1;
            r_wdata  <= s_wdata;
            r_wstrb  <= s_wstrb;
        end else if (!r_w_full && (r_wstate == W_IDLE)) begin
            r_wready <= 1'b1;
        end
    end

    // Write FSM. W_COMMIT is entered on the edge that fills the second
    // holder, so the bank write and bvalid land exactly one edge later.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wstate <= W_IDLE;
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if ((r_aw_full || w_aw_hs) && (r_w_full || w_w_hs)) begin
                        r_wstate <= W_COMMIT;
                    end
                end
                W_COMMIT: begin
                    r_bvalid <= 1'b1;
                    r_bresp  <= w_wr_hit ? RESP_OKAY : RESP_DECERR;
                    r_wstate <= W_RESP;
                end
                W_RESP: begin
                    if (w_b_hs) begin
                        r_bvalid <= 1'b0;
                        r_wstate <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Read FSM. The pending flag marks a captured address whose data is
    // loaded on the following edge; loading from the bank's current
    // contents gives pre-write data when a commit shares that edge.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_arready <= 1'b0;
            r_ar_pend <= 1'b0;
            r_araddr  <= 32'h0;
            r_rstate  <= R_IDLE;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'h0;
            r_rresp   <= RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_arready <= 1'b0;
                        r_ar_pend <= 1'b1;
                        r_araddr  <= s_araddr;
                    end else if (r_ar_pend) begin
                        r_ar_pend <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_rd_hit ? w_bank_rd : 32'h0;
                        r_rresp   <= w_rd_hit ? RESP_OKAY : RESP_DECERR;
                        r_rstate  <= R_RESP;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (w_r_hs) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    axi4_lite_reg_bank #(
        .NUM_REGS  (NUM_REGS),
        .RESET_VAL (RESET_VAL),
        .IDX_W     (c_IDX_W)
    ) u_bank (
        .clk            (aclk),
        .rst            (areset),
        .i_wr_en        (w_wr_en),
        .i_wr_idx       (w_wr_idx),
        .i_wr_data      (r_wdata),
        .i_wr_strb      (r_wstrb),
        .i_rd_idx       (w_rd_idx),
        .o_rd_data      (w_bank_rd),
        .o_reg_q        (reg_q),
        .o_reg_wr_pulse (reg_wr_pulse)
    );

    assign s_awready = r_awready;
    assign s_wready  = r_wready;
    assign s_bvalid  = r_bvalid;
    assign s_bresp   = r_bresp;
    assign s_arready = r_arready;
    assign s_rvalid  = r_rvalid;
    assign s_rdata   = r_rdata;
    assign s_rresp   = r_rresp;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_slave_regs
// Purpose  : Self-checking bench for axi4_lite_slave_regs: directed cases
//            plus randomized traffic against an array-based register model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_slave_regs;

    localparam int          c_NR   = 12;
    localparam logic [31:0] c_BASE = 32'h0000_1040;
    localparam logic [31:0] c_RV   = 32'hDEAD_BEEF;
    localparam int          c_TMO  = 50;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    logic [31:0] s_awaddr = '0;  logic [3:0] s_awcache = '0; logic [2:0] s_awprot = '0;
    logic s_awvalid = 1'b0, s_awready;
    logic [31:0] s_wdata = '0;   logic [3:0] s_wstrb = '0;
    logic s_wvalid = 1'b0, s_wready;
    logic [1:0] s_bresp; logic s_bvalid; logic s_bready = 1'b0;
    logic [31:0] s_araddr = '0;  logic [3:0] s_arcache = '0; logic [2:0] s_arprot = '0;
    logic s_arvalid = 1'b0, s_arready;
    logic [31:0] s_rdata; logic [1:0] s_rresp; logic s_rvalid; logic s_rready = 1'b0;
    logic [c_NR*32-1:0] reg_q;
    logic [c_NR-1:0]    reg_wr_pulse;

    axi4_lite_slave_regs #(
        .NUM_REGS(c_NR), .BASE_ADDR(c_BASE), .RESET_VAL(c_RV)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_awaddr(s_awaddr), .s_awcache(s_awcache), .s_awprot(s_awprot),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arcache(s_arcache), .s_arprot(s_arprot),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int pulse_cnt [c_NR] = '{default: 0};
    always @(negedge aclk) begin
        for (int k = 0; k < c_NR; k++) pulse_cnt[k] <= pulse_cnt[k] + int'(reg_wr_pulse[k]);
    end

    // Reference model
    logic [31:0] mdl [c_NR];
    int exp_pulse [c_NR] = '{default: 0};
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit m_hit(input logic [31:0] a);
        return (a >= c_BASE) && (((a - c_BASE) / 4) < c_NR);
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a - c_BASE) / 4);
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int i;
        if (m_hit(a)) begin
            i = m_idx(a);
            for (int b = 0; b < 4; b++) if (s[b]) mdl[i][8*b +: 8] = d[8*b +: 8];
            exp_pulse[i]++;
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < c_NR; k++) mdl[k] = c_RV;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        return m_hit(a) ? mdl[m_idx(a)] : 32'h0;
    endfunction

    task automatic chk_regs(input string tag);
        for (int k = 0; k < c_NR; k++) chk(tag, reg_q[32*k +: 32], mdl[k]);
    endtask

    // All bus tasks start and end at posedge+1.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input int b_dly, output logic [1:0] resp);
        int aw_c, w_c, b_c;
        aw_c = -1; w_c = -1; b_c = -1;
        fork
            begin
                for (int i = 0; i < aw_dly; i++) begin @(posedge aclk); #1; end
                s_awaddr = addr; s_awcache = 4'($urandom); s_awprot = 3'($urandom);
                s_awvalid = 1'b1;
                for (int n = 0; n < c_TMO; n++) begin
                    @(negedge aclk);
                    if (s_awready) begin aw_c = cyc + 1; break; end
                end
                if (aw_c < 0) chk("aw_timeout", 0, 1);
                @(posedge aclk); #1; s_awvalid = 1'b0;
            end
            begin
                for (int i = 0; i < w_dly; i++) begin @(posedge aclk); #1; end
                s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1;
                for (int n = 0; n < c_TMO; n++) begin
                    @(negedge aclk);
                    if (s_wready) begin w_c = cyc + 1; break; end
                end
                if (w_c < 0) chk("w_timeout", 0, 1);
                @(posedge aclk); #1; s_wvalid = 1'b0;
            end
        join
        for (int n = 0; n < c_TMO; n++) begin
            @(negedge aclk);
            if (s_bvalid) begin b_c = cyc; break; end
        end
        if (b_c < 0) chk("b_timeout", 0, 1);
        else chk("b_latency", b_c, ((aw_c > w_c) ? aw_c : w_c) + 1);
        resp = s_bresp;
        for (int i = 0; i < b_dly; i++) begin
            chk("b_hold", {s_bvalid, s_bresp}, {1'b1, resp});
            chk("b_hold_rdy", {s_awready, s_wready}, 2'b00);
            @(negedge aclk);
        end
        s_bready = 1'b1;
        @(posedge aclk); #1; s_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                            output logic [31:0] data, output logic [1:0] resp);
        int ar_c, r_c;
        ar_c = -1; r_c = -1;
        for (int i = 0; i < ar_dly; i++) begin @(posedge aclk); #1; end
        s_araddr = addr; s_arcache = 4'($urandom); s_arprot = 3'($urandom);
        s_arvalid = 1'b1;
        for (int n = 0; n < c_TMO; n++) begin
            @(negedge aclk);
            if (s_arready) begin ar_c = cyc + 1; break; end
        end
        if (ar_c < 0) chk("ar_timeout", 0, 1);
        @(posedge aclk); #1; s_arvalid = 1'b0;
        for (int n = 0; n < c_TMO; n++) begin
            @(negedge aclk);
            if (s_rvalid) begin r_c = cyc; break; end
        end
        if (r_c < 0) chk("r_timeout", 0, 1);
        else chk("r_latency", r_c, ar_c + 1);
        data = s_rdata; resp = s_rresp;
        for (int i = 0; i < r_dly; i++) begin
            chk("r_hold", {s_rvalid, s_rresp, s_rdata}, {1'b1, resp, data});
            chk("r_hold_rdy", s_arready, 1'b0);
            @(negedge aclk);
        end
        s_rready = 1'b1;
        @(posedge aclk); #1; s_rready = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned sel;
        logic [31:0] a;
        sel = $urandom_range(0, 9);
        if (sel == 0)      a = c_BASE - 32'(4 * $urandom_range(1, 4));
        else if (sel == 1) a = c_BASE + 32'(4 * (c_NR + $urandom_range(0, 3)));
        else               a = c_BASE + 32'(4 * $urandom_range(0, c_NR - 1));
        return a | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [1:0]  bresp, rresp;
        logic [31:0] rdata, old, waddr, raddr, wdata;
        logic [3:0]  wstrb;
        int p0, op;

        m_reset();

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_rdy", {s_awready, s_wready, s_arready}, 3'b000);
        chk("rst_valid", {s_bvalid, s_rvalid}, 2'b00);
        chk("rst_data", {s_bresp, s_rresp, s_rdata, reg_wr_pulse}, '0);
        chk_regs("rst_regq");
        areset = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        chk("rdy_rise", {s_awready, s_wready, s_arready}, 3'b111);
        @(posedge aclk); #1;

        // Read after reset
        axi_read(c_BASE + 32'h0C, 0, 0, rdata, rresp);
        chk("rst_rd_data", rdata, c_RV);
        chk("rst_rd_resp", rresp, 2'b00);

        // Byte-strobe merge
        axi_write(c_BASE + 32'h04, 32'hA5A5_1234, 4'hF, 0, 0, 0, bresp);
        m_write(c_BASE + 32'h04, 32'hA5A5_1234, 4'hF);
        chk("wr1_resp", bresp, 2'b00);
        axi_write(c_BASE + 32'h04, 32'hFFFF_FFFF, 4'b0101, 0, 0, 0, bresp);
        m_write(c_BASE + 32'h04, 32'hFFFF_FFFF, 4'b0101);
        axi_read(c_BASE + 32'h04, 0, 0, rdata, rresp);
        chk("strb_rd", rdata, 32'hA5FF_12FF);
        chk("strb_pulse", pulse_cnt[1], 2);
        @(negedge aclk);
        chk("rdy_back", {s_awready, s_wready, s_arready}, 3'b111);
        @(posedge aclk); #1;

        // W three cycles ahead of AW: latency checked inside the task
        p0 = pulse_cnt[3];
        axi_write(c_BASE + 32'h0C, 32'h1357_9BDF, 4'hF, 3, 0, 0, bresp);
        m_write(c_BASE + 32'h0C, 32'h1357_9BDF, 4'hF);
        chk("wfirst_resp", bresp, 2'b00);
        chk("wfirst_pulse", pulse_cnt[3] - p0, 1);

        // Zero strobe: OKAY, unchanged, pulse still fires
        p0 = pulse_cnt[3];
        axi_write(c_BASE + 32'h0C, 32'hFFFF_FFFF, 4'h0, 0, 2, 0, bresp);
        m_write(c_BASE + 32'h0C, 32'hFFFF_FFFF, 4'h0);
        chk("zstrb_resp", bresp, 2'b00);
        chk("zstrb_pulse", pulse_cnt[3] - p0, 1);
        chk_regs("zstrb_regq");

        // Out of range just past the top and just below the base
        axi_write(c_BASE + 32'(c_NR * 4), 32'h1111_2222, 4'hF, 0, 0, 0, bresp);
        chk("oor_bresp", bresp, 2'b11);
        axi_read(c_BASE + 32'(c_NR * 4), 0, 0, rdata, rresp);
        chk("oor_rresp", rresp, 2'b11);
        chk("oor_rdata", rdata, 32'h0);
        axi_write(c_BASE - 32'h4, 32'h3333_4444, 4'hF, 1, 0, 0, bresp);
        chk("below_bresp", bresp, 2'b11);
        chk_regs("oor_regq");

        // Back-pressure on both responses for five cycles, concurrently
        fork
            axi_write(c_BASE + 32'h10, 32'hCAFE_F00D, 4'hF, 0, 0, 5, bresp);
            axi_read(c_BASE + 32'h14, 0, 5, rdata, rresp);
        join
        chk("bp_rdata", rdata, mdl[5]);
        m_write(c_BASE + 32'h10, 32'hCAFE_F00D, 4'hF);
        chk("bp_bresp", bresp, 2'b00);

        // Read loading on the same edge as a commit to the same register
        old = mdl[6];
        fork
            axi_write(c_BASE + 32'h18, 32'h0BAD_CAFE, 4'hF, 0, 0, 0, bresp);
            axi_read(c_BASE + 32'h18, 0, 0, rdata, rresp);
        join
        chk("same_edge_rd", rdata, old);
        m_write(c_BASE + 32'h18, 32'h0BAD_CAFE, 4'hF);
        chk_regs("same_edge_regq");

        // Randomized traffic; concurrent ops target different registers
        for (int it = 0; it < 100; it++) begin
            op = int'($urandom_range(0, 2));
            waddr = rand_addr();
            raddr = rand_addr();
            wdata = $urandom;
            wstrb = 4'($urandom);
            if (op == 0) begin
                axi_write(waddr, wdata, wstrb, int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), bresp);
                chk("rnd_bresp", bresp, m_hit(waddr) ? 2'b00 : 2'b11);
                m_write(waddr, wdata, wstrb);
            end else if (op == 1) begin
                axi_read(raddr, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), rdata, rresp);
                chk("rnd_rresp", rresp, m_hit(raddr) ? 2'b00 : 2'b11);
                chk("rnd_rdata", rdata, m_read(raddr));
            end else begin
                if (m_hit(waddr) && m_hit(raddr) && (m_idx(waddr) == m_idx(raddr)))
                    raddr = c_BASE + 32'(4 * ((m_idx(waddr) + 1) % c_NR));
                old = m_read(raddr);
                fork
                    axi_write(waddr, wdata, wstrb, int'($urandom_range(0, 3)),
                              int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), bresp);
                    axi_read(raddr, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), rdata, rresp);
                join
                chk("rnd2_bresp", bresp, m_hit(waddr) ? 2'b00 : 2'b11);
                chk("rnd2_rresp", rresp, m_hit(raddr) ? 2'b00 : 2'b11);
                chk("rnd2_rdata", rdata, old);
                m_write(waddr, wdata, wstrb);
            end
        end
        chk_regs("rnd_regq");
        @(negedge aclk);
        for (int k = 0; k < c_NR; k++) chk("pulse_cnt", pulse_cnt[k], exp_pulse[k]);
        @(posedge aclk); #1;

        // Reset while a write response is outstanding
        s_awaddr = c_BASE + 32'h08; s_wdata = 32'h7777_8888; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        @(negedge aclk);
        chk("mr_rdy", {s_awready, s_wready}, 2'b11);
        @(posedge aclk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        m_write(c_BASE + 32'h08, 32'h7777_8888, 4'hF);
        @(negedge aclk);
        @(negedge aclk);
        chk("mr_bvalid", s_bvalid, 1'b1);
        chk("mr_reg", reg_q[32*2 +: 32], 32'h7777_8888);
        areset = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        m_reset();
        chk("mr_bvalid_clr", s_bvalid, 1'b0);
        chk("mr_rdy_low", {s_awready, s_wready, s_arready}, 3'b000);
        chk_regs("mr_regq");
        areset = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        chk("mr_rdy_high", {s_awready, s_wready, s_arready}, 3'b111);
        @(negedge aclk);
        chk("mr_no_b", {s_bvalid, s_rvalid}, 2'b00);
        @(posedge aclk); #1;
        axi_read(c_BASE + 32'h08, 0, 0, rdata, rresp);
        chk("mr_rd", rdata, c_RV);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
